// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: owns the PC, fetches over a req/ack handshake, issues one slot.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h18C0,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic        instrValid,
    input  logic        jmpFlag,
    input  logic [31:0] jmpAddress,
    input  logic        branchFlag,
    input  logic        zeroFlag,
    input  logic [31:0] branchOffset,
    output logic [31:0] pc,
    output logic        flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] issueCount,
    output logic [31:0] takenCount,
`endif
    output logic        fetchError
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        req_q;
    logic        flush_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic        jump_taken;
    logic        branch_taken;
    logic        issue_exit;

    // Next-PC selection; jump outranks branch, so a simultaneous branch never flushes.
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        jump_taken   = jmpFlag;
        branch_taken = 1'b0;
        pc_d         = pc_q + 32'd4;
        if (jmpFlag) begin
            pc_d = RESET_VECTOR + jmpAddress;
        end else if (branchFlag && !zeroFlag) begin
            branch_taken = 1'b1;
            pc_d         = pc_q + branchOffset - 32'd4;
        end
    end

    assign issue_exit = (state_q == S_ISSUE) && !stall;

    // NOTE: state uses non-blocking assignments only, and the async reset clears imemReq
    // immediately so an abandoned fetch is never seen by memory after reset asserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (imemAck) begin
                        instr_q <= imemData;
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                        cnt_q   <= cnt_q + 8'd1;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        flush_q <= branch_taken;
                        if (run) begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_ERROR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] taken_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_cnt_q <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else if (issue_exit) begin
            if (issue_cnt_q != 32'hFFFF_FFFF) issue_cnt_q <= issue_cnt_q + 32'd1;
            if ((jump_taken || branch_taken) && taken_cnt_q != 32'hFFFF_FFFF)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign issueCount = issue_cnt_q;
    assign takenCount = taken_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = issue_exit;
`endif

    assign imemReq    = req_q;
    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign instrValid = valid_q;
    assign pc         = pc_q;
    assign flush      = flush_q;
    assign fetchError = err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the program counter.
- Issues one request at a time to instruction memory over a req/ack handshake and presents each fetched instruction to decode for one issue slot.
- Selects the next PC (sequential, jump, or branch) from decode/ALU resolution signals sampled in that slot.
- Sits between instruction memory and decode; replaces free-running PC stepping for memories with variable latency.

Parameters:
- RESET_VECTOR, 32'h18C0, PC after reset; also the base added to jump targets.
- ACK_TIMEOUT, 15, max cycles waiting for imemAck before error (1..255).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = sequencer may start new fetches
- stall  in  1  downstream hold; freezes the issue slot
- imemReq  out  1  fetch request
- imemAddr  out  32  fetch address (= pc)
- imemAck  in  1  memory returns data this cycle
- imemData  in  32  instruction word, valid with imemAck
- instr  out  32  latched instruction
- instrValid  out  1  issue slot active
- jmpFlag  in  1  current instruction is a jump
- jmpAddress  in  32  jump offset from RESET_VECTOR
- branchFlag  in  1  current instruction is a conditional branch
- zeroFlag  in  1  ALU zero; branch taken when 0
- branchOffset  in  32  signed byte offset
- pc  out  32  address of the instruction in the slot
- flush  out  1  one-cycle pulse on taken branch
- fetchError  out  1  sticky ack timeout

Behaviour:
- reset low (async): state IDLE, pc=RESET_VECTOR, instr=0, instrValid=0, imemReq=0, flush=0, fetchError=0, timeout counter=0. Reset mid-fetch abandons the request; a late imemAck is ignored.
- States: IDLE, FETCH, ISSUE, ERROR.
- IDLE:
  - imemReq=0.
  - run=1 -> FETCH next edge; otherwise remain.
- FETCH:
  - imemReq=1, imemAddr=pc.
  - Counter increments each cycle without ack.
  - imemAck=1 -> instr<=imemData, counter<=0, -> ISSUE. An ack in the first FETCH cycle is legal; minimum fetch latency is 1 cycle.
  - Counter reaching ACK_TIMEOUT with no ack -> ERROR, fetchError<=1.
  - imemReq stays high until ack. run falling during FETCH does not cancel the request.
- ISSUE:
  - instrValid=1, imemReq=0.
  - While stall=1: hold everything, and ignore resolution inputs.
  - When stall=0, evaluate next PC on the edge. Priority: jump > branch > sequential.
    - jmpFlag: pc <= RESET_VECTOR + jmpAddress.
    - branchFlag && !zeroFlag: pc <= pc + $signed(branchOffset) - 4; flush=1 for the following cycle.
    - else: pc <= pc + 4.
  - Then -> FETCH if run=1, else -> IDLE.
- ERROR:
  - All strobes 0, pc frozen, fetchError=1.
  - Exit only via reset.
- Arithmetic: 32-bit modulo; wrap from 32'hFFFFFFFC to 0 is silent.
- Jump and branch both set: jump wins, no flush.
- flush is registered and never coincides with instrValid for the same instruction.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs issueCount[31:0] and takenCount[31:0].
  - issueCount increments on each ISSUE exit.
  - takenCount increments on each taken branch or jump.
  - Both reset to 0, saturate at all-ones.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset release, run=1, imemAck 2 cycles after imemReq -> imemAddr=32'h18C0; instr latched; instrValid for 1 cycle; next imemAddr=32'h18C4.
- Issue slot with jmpFlag=1, jmpAddress=32'h40 -> next imemAddr=32'h1900, flush stays 0.
- pc=32'h18D0, branchFlag=1, zeroFlag=0, branchOffset=-8 -> next pc=32'h18C4, flush=1 exactly one cycle; zeroFlag=1 repeat -> pc=32'h18D4, no flush.
- stall=1 for 3 cycles in ISSUE with jmpFlag toggling -> instrValid held 3+1 cycles, pc unchanged until stall drops, then target taken from final-cycle inputs.
- imemAck never asserted -> fetchError rises after ACK_TIMEOUT=15 cycles, imemReq drops, stays until reset low; reset low mid-FETCH -> imemReq=0 immediately (async).
- FETCH_PERF_CNT_EN: 5 sequential + 2 taken branches -> issueCount=7, takenCount=2.
